pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage core. It detects load-use

---
 rtl/pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage core. It resolves load-use hazards
//   that forwarding cannot cover, runs multi-cycle EX operations through a
//   start/done handshake with a timeout, and applies data-memory freeze and
//   branch redirect flushes. It also keeps saturating stall and flush counters.
//   Pipeline control outputs are combinational from the FSM state and the inputs.
module pipeline_hazard_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [4:0]           id_rs1_addr_i,
  input  logic [4:0]           id_rs2_addr_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  input  logic                 ex_mem_read_i,
  input  logic [4:0]           ex_rd_addr_i,
  input  logic                 ex_mc_valid_i,
  input  logic                 mc_done_i,
  input  logic                 ex_branch_taken_i,
  input  logic                 dmem_stall_i,
  output logic                 pc_write_en_o,
  output logic                 if_id_write_en_o,
  output logic                 id_ex_write_en_o,
  output logic                 ex_mem_write_en_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_bubble_o,
  output logic                 mc_start_o,
  output logic                 mc_error_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  // The timeout counter only needs to reach MC_TIMEOUT-1; the FSM leaves
  // MC_WAIT on that cycle, so the counter never wraps.
  localparam int TO_W = $clog2(MC_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    MC_HOLD = 2'd2
  } state_e;

  state_e                state_q,  state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  mc_err_q, mc_err_d;
  logic [CNT_WIDTH-1:0]  stall_q,  stall_d;
  logic [CNT_WIDTH-1:0]  flush_q,  flush_d;

  logic load_use_s;
  logic timeout_s;
  logic flush_inc_s;

  // Hazard when the EX load writes a non-zero register that ID actually reads.
  always_comb begin
    load_use_s = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                 ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                  (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));
    timeout_s  = (state_q == MC_WAIT) && !mc_done_i && (to_cnt_q == TO_LAST);
  end

  // Next-state, pipeline-control outputs and counter/flag next values.
  always_comb begin
    pc_write_en_o     = 1'b1;
    if_id_write_en_o  = 1'b1;
    id_ex_write_en_o  = 1'b1;
    ex_mem_write_en_o = 1'b1;
    if_id_flush_o     = 1'b0;
    id_ex_flush_o     = 1'b0;
    ex_mem_bubble_o   = 1'b0;
    mc_start_o        = 1'b0;
    state_d           = state_q;
    to_cnt_d          = to_cnt_q;
    mc_err_d          = mc_err_q;
    flush_inc_s       = 1'b0;

    if (rst_i) begin
      // Hold the whole pipe quiet while in reset; registers clear on the edge.
      pc_write_en_o     = 1'b0;
      if_id_write_en_o  = 1'b0;
      id_ex_write_en_o  = 1'b0;
      ex_mem_write_en_o = 1'b0;
      state_d           = RUN;
      to_cnt_d          = '0;
      mc_err_d          = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (dmem_stall_i) begin
            pc_write_en_o     = 1'b0;
            if_id_write_en_o  = 1'b0;
            id_ex_write_en_o  = 1'b0;
            ex_mem_write_en_o = 1'b0;
          end else if (ex_mc_valid_i) begin
            mc_start_o       = 1'b1;
            pc_write_en_o    = 1'b0;
            if_id_write_en_o = 1'b0;
            id_ex_write_en_o = 1'b0;
            ex_mem_bubble_o  = 1'b1;
            to_cnt_d         = '0;
            state_d          = MC_WAIT;
          end else if (ex_branch_taken_i) begin
            // Redirect wins over a load-use hazard: the dependent ID
            // instruction is on the wrong path and gets flushed anyway.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            flush_inc_s   = 1'b1;
          end else if (load_use_s) begin
            pc_write_en_o    = 1'b0;
            if_id_write_en_o = 1'b0;
            id_ex_flush_o    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end

        MC_WAIT: begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (timeout_s) begin
            mc_err_d = 1'b1;
          end else begin
            mc_err_d = mc_err_q;
          end
          if (mc_done_i || timeout_s) begin
            if (dmem_stall_i) begin
              pc_write_en_o     = 1'b0;
              if_id_write_en_o  = 1'b0;
              id_ex_write_en_o  = 1'b0;
              ex_mem_write_en_o = 1'b0;
              state_d           = MC_HOLD;
            end else begin
              state_d = RUN;
            end
          end else begin
            pc_write_en_o    = 1'b0;
            if_id_write_en_o = 1'b0;
            id_ex_write_en_o = 1'b0;
            ex_mem_bubble_o  = 1'b1;
          end
        end

        MC_HOLD: begin
          if (dmem_stall_i) begin
            pc_write_en_o     = 1'b0;
            if_id_write_en_o  = 1'b0;
            id_ex_write_en_o  = 1'b0;
            ex_mem_write_en_o = 1'b0;
          end else begin
            state_d = RUN;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end

    if (rst_i) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      stall_d = (!pc_write_en_o && (stall_q != '1)) ? stall_q + CNT_ONE : stall_q;
      flush_d = (flush_inc_s && (flush_q != '1)) ? flush_q + CNT_ONE : flush_q;
    end
  end

  // State, timeout counter, sticky error and performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      to_cnt_q <= '0;
      mc_err_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      mc_err_q <= mc_err_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign mc_error_o     = mc_err_q;
  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (CNT_WIDTH=4, MC_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mc_valid, mc_done;
  logic       ex_branch_taken, dmem_stall;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic       if_id_flush, id_ex_flush, ex_mem_bubble, mc_start, mc_error;
  logic [3:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.CNT_WIDTH(4), .MC_TIMEOUT(8)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .id_rs1_addr_i     (id_rs1_addr),
    .id_rs2_addr_i     (id_rs2_addr),
    .id_uses_rs1_i     (id_uses_rs1),
    .id_uses_rs2_i     (id_uses_rs2),
    .ex_mem_read_i     (ex_mem_read),
    .ex_rd_addr_i      (ex_rd_addr),
    .ex_mc_valid_i     (ex_mc_valid),
    .mc_done_i         (mc_done),
    .ex_branch_taken_i (ex_branch_taken),
    .dmem_stall_i      (dmem_stall),
    .pc_write_en_o     (pc_we),
    .if_id_write_en_o  (if_id_we),
    .id_ex_write_en_o  (id_ex_we),
    .ex_mem_write_en_o (ex_mem_we),
    .if_id_flush_o     (if_id_flush),
    .id_ex_flush_o     (id_ex_flush),
    .ex_mem_bubble_o   (ex_mem_bubble),
    .mc_start_o        (mc_start),
    .mc_error_o        (mc_error),
    .stall_cycles_o    (stall_cycles),
    .flush_count_o     (flush_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enables as {pc, if_id, id_ex, ex_mem}; controls as {if_id_flush, id_ex_flush, bubble, mc_start}.
  task automatic check_out(input string tag, input logic [3:0] en, input logic [3:0] ctl);
    #1;
    check({tag, "_en"},  {12'd0, pc_we, if_id_we, id_ex_we, ex_mem_we}, {12'd0, en});
    check({tag, "_ctl"}, {12'd0, if_id_flush, id_ex_flush, ex_mem_bubble, mc_start}, {12'd0, ctl});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_mc_valid = 1'b0; mc_done = 1'b0; ex_branch_taken = 1'b0; dmem_stall = 1'b0;
    tick();
    tick();
    // Outputs held low during reset
    check_out("rst_outs", 4'b0000, 4'b0000);
    rst = 1'b0;
    check_out("run_idle", 4'b1111, 4'b0000);
    check("rst_stall", {12'd0, stall_cycles}, 16'd0);
    check("rst_flush", {12'd0, flush_count}, 16'd0);
    check("rst_err", {15'd0, mc_error}, 16'd0);

    // 1: load-use on rs1 -> single bubble
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    check_out("lu_rs1", 4'b0011, 4'b0100);
    tick();
    ex_mem_read = 1'b0;
    check_out("lu_after", 4'b1111, 4'b0000);
    check("lu_stall", {12'd0, stall_cycles}, 16'd1);
    // x0 destination never stalls
    ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
    check_out("lu_x0", 4'b1111, 4'b0000);
    tick();
    // rs2 dependency, rs1 unused
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd7; ex_rd_addr = 5'd7;
    check_out("lu_rs2", 4'b0011, 4'b0100);
    tick();
    ex_mem_read = 1'b0;
    check("lu_stall2", {12'd0, stall_cycles}, 16'd2);

    // 4: branch overrides simultaneous load-use
    ex_mem_read = 1'b1; ex_branch_taken = 1'b1;
    check_out("br_lu", 4'b1111, 4'b1100);
    tick();
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; id_uses_rs2 = 1'b0;
    check("br_flush", {12'd0, flush_count}, 16'd1);
    check("br_stall", {12'd0, stall_cycles}, 16'd2);

    // 2: multi-cycle op, done at cycle 4
    do_reset();
    ex_mc_valid = 1'b1;
    check_out("mc_c0", 4'b0001, 4'b0011);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_out($sformatf("mc_c%0d", i), 4'b0001, 4'b0010);
    end
    tick();
    mc_done = 1'b1;
    check_out("mc_c4", 4'b1111, 4'b0000);
    tick();
    mc_done = 1'b0; ex_mc_valid = 1'b0;
    check_out("mc_run", 4'b1111, 4'b0000);
    check("mc_stall", {12'd0, stall_cycles}, 16'd4);

    // 5: done arrives under dmem_stall -> MC_HOLD for 3 frozen cycles
    ex_mc_valid = 1'b1;
    check_out("hold_c0", 4'b0001, 4'b0011);
    tick();
    ex_mc_valid = 1'b0;
    check_out("hold_c1", 4'b0001, 4'b0010);
    tick();
    mc_done = 1'b1; dmem_stall = 1'b1;
    check_out("hold_c2", 4'b0000, 4'b0000);
    tick();
    mc_done = 1'b0;
    check_out("hold_c3", 4'b0000, 4'b0000);
    tick();
    check_out("hold_c4", 4'b0000, 4'b0000);
    tick();
    dmem_stall = 1'b0;
    check_out("hold_rel", 4'b1111, 4'b0000);
    tick();
    check_out("hold_run", 4'b1111, 4'b0000);
    check("hold_stall", {12'd0, stall_cycles}, 16'd9);

    // 3: timeout after 8 MC_WAIT cycles
    do_reset();
    ex_mc_valid = 1'b1;
    check_out("to_c0", 4'b0001, 4'b0011);
    tick();
    ex_mc_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      check_out($sformatf("to_w%0d", i), 4'b0001, 4'b0010);
      check($sformatf("to_err%0d", i), {15'd0, mc_error}, 16'd0);
      tick();
    end
    check_out("to_w8", 4'b1111, 4'b0000);
    check("to_err8", {15'd0, mc_error}, 16'd0);
    tick();
    check("to_err_set", {15'd0, mc_error}, 16'd1);
    check("to_stall", {12'd0, stall_cycles}, 16'd8);
    ex_branch_taken = 1'b1;
    check_out("to_run_br", 4'b1111, 4'b1100);
    tick();
    ex_branch_taken = 1'b0;
    tick();
    tick();
    check("to_err_hold", {15'd0, mc_error}, 16'd1);

    // 6: reset during MC_WAIT
    ex_mc_valid = 1'b1;
    tick();
    ex_mc_valid = 1'b0;
    check_out("rw_wait", 4'b0001, 4'b0010);
    rst = 1'b1;
    check_out("rw_rst", 4'b0000, 4'b0000);
    tick();
    rst = 1'b0;
    check_out("rw_run", 4'b1111, 4'b0000);
    check("rw_stall", {12'd0, stall_cycles}, 16'd0);
    check("rw_flush", {12'd0, flush_count}, 16'd0);
    check("rw_err", {15'd0, mc_error}, 16'd0);

    // Saturation of both 4-bit counters
    dmem_stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    dmem_stall = 1'b0;
    check("sat_stall", {12'd0, stall_cycles}, 16'd15);
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    ex_branch_taken = 1'b0;
    tick();
    check("sat_flush", {12'd0, flush_count}, 16'd15);
    check("sat_stall2", {12'd0, stall_cycles}, 16'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
